// File: rtl/instr_pipe_track_pkg.sv
// Shared MIPS pipeline definitions: the bubble word, instruction field positions
// and the word+write-enable stage record. The redirection unit uses this package too.
package instr_pipe_track_pkg;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;  // sll $0,$0,0

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef struct packed {
    logic [31:0] word;
    logic        we;
  } stage_t;

  function automatic logic [5:0] get_op(input logic [31:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [5:0] get_funct(input logic [31:0] w);
    return w[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/instr_pipe_track_stage_reg.sv
// One pipeline stage: 33-bit word+WE register with clear and hold.
// Priority reset > clear > hold > load; a NOP word never carries WE=1.
module pipe_stage_reg
  import instr_pipe_track_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = MIPS_NOP
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clr_i,
  input  logic   hold_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (clr_i) begin
      stage_d.word = NOP_WORD;
      stage_d.we   = 1'b0;
    end else if (!hold_i) begin
      stage_d.word = d_i.word;
      stage_d.we   = d_i.we && (d_i.word != NOP_WORD);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q.word <= NOP_WORD;
      stage_q.we   <= 1'b0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/instr_pipe_track.sv
// Tracks the instruction word and register-write enable through ID/EX/MEM/WB,
// with flush/bubble insertion and saturating stall and flush event counters.
module instr_pipe_track
  import instr_pipe_track_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = MIPS_NOP,
  parameter int          CNT_W    = 16
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic [31:0]      in_IF_IS,
  input  logic             in_IF_VALID,
  input  logic             in_PEN,
  input  logic             in_BEN,
  input  logic             in_FDCLR,
  input  logic             in_DECLR,
  input  logic             in_WE_DEC,
  output logic [31:0]      out_IS,
  output logic [31:0]      out_PIS,
  output logic [31:0]      out_PPIS,
  output logic [31:0]      out_PPPIS,
  output logic             out_PPWE,
  output logic             out_PPPWE,
  output logic [CNT_W-1:0] out_STALLCNT,
  output logic [CNT_W-1:0] out_FLUSHCNT
);

  stage_t id_d, ex_d;
  stage_t id_q, ex_q, mem_q, wb_q;
  logic   id_hold;

  // ID's WE bit marks a real (non-bubble) word, gating the decoded WE into EX
  assign id_d.word = in_IF_VALID ? in_IF_IS : NOP_WORD;
  assign id_d.we   = 1'b1;
  assign id_hold   = !(in_BEN && in_PEN);

  assign ex_d.word = id_q.word;
  assign ex_d.we   = in_WE_DEC && id_q.we;

  pipe_stage_reg #(.NOP_WORD(NOP_WORD)) u_id (
    .clk_i(in_CLK), .rst_ni(in_RST), .clr_i(in_FDCLR), .hold_i(id_hold),
    .d_i(id_d), .q_o(id_q)
  );

  pipe_stage_reg #(.NOP_WORD(NOP_WORD)) u_ex (
    .clk_i(in_CLK), .rst_ni(in_RST), .clr_i(in_DECLR), .hold_i(1'b0),
    .d_i(ex_d), .q_o(ex_q)
  );

  pipe_stage_reg #(.NOP_WORD(NOP_WORD)) u_mem (
    .clk_i(in_CLK), .rst_ni(in_RST), .clr_i(1'b0), .hold_i(1'b0),
    .d_i(ex_q), .q_o(mem_q)
  );

  pipe_stage_reg #(.NOP_WORD(NOP_WORD)) u_wb (
    .clk_i(in_CLK), .rst_ni(in_RST), .clr_i(1'b0), .hold_i(1'b0),
    .d_i(mem_q), .q_o(wb_q)
  );

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (in_DECLR && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (in_FDCLR && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_IS       = id_q.word;
  assign out_PIS      = ex_q.word;
  assign out_PPIS     = mem_q.word;
  assign out_PPPIS    = wb_q.word;
  assign out_PPWE     = mem_q.we;
  assign out_PPPWE    = wb_q.we;
  assign out_STALLCNT = stall_cnt_q;
  assign out_FLUSHCNT = flush_cnt_q;

endmodule

// File: tb/tb_instr_pipe_track.sv
// Directed bench: issue, load-use stall, flush, saturation, PEN hold and reset mid-stall.
// A second instance with 2-bit counters exercises saturation in a few cycles.
module tb_instr_pipe_track;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_is;
  logic        if_valid, pen, ben, fdclr, declr, we_dec;

  logic [31:0] is_o, pis_o, ppis_o, pppis_o;
  logic        ppwe_o, pppwe_o;
  logic [15:0] stall_o, flush_o;

  logic [31:0] s_is, s_pis, s_ppis, s_pppis;
  logic        s_ppwe, s_pppwe;
  logic [1:0]  s_stall, s_flush;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_pipe_track dut (
    .in_CLK(clk), .in_RST(rst), .in_IF_IS(if_is), .in_IF_VALID(if_valid),
    .in_PEN(pen), .in_BEN(ben), .in_FDCLR(fdclr), .in_DECLR(declr), .in_WE_DEC(we_dec),
    .out_IS(is_o), .out_PIS(pis_o), .out_PPIS(ppis_o), .out_PPPIS(pppis_o),
    .out_PPWE(ppwe_o), .out_PPPWE(pppwe_o), .out_STALLCNT(stall_o), .out_FLUSHCNT(flush_o)
  );

  instr_pipe_track #(.CNT_W(2)) dut_sat (
    .in_CLK(clk), .in_RST(rst), .in_IF_IS(if_is), .in_IF_VALID(if_valid),
    .in_PEN(pen), .in_BEN(ben), .in_FDCLR(fdclr), .in_DECLR(declr), .in_WE_DEC(we_dec),
    .out_IS(s_is), .out_PIS(s_pis), .out_PPIS(s_ppis), .out_PPPIS(s_pppis),
    .out_PPWE(s_ppwe), .out_PPPWE(s_pppwe), .out_STALLCNT(s_stall), .out_FLUSHCNT(s_flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pipe(input string tag, input logic [31:0] e_is, input logic [31:0] e_pis,
                          input logic [31:0] e_ppis, input logic e_ppwe,
                          input logic [31:0] e_pppis, input logic e_pppwe);
    check({tag, ".IS"},    is_o,    e_is);
    check({tag, ".PIS"},   pis_o,   e_pis);
    check({tag, ".PPIS"},  ppis_o,  e_ppis);
    check({tag, ".PPWE"},  {31'd0, ppwe_o},  {31'd0, e_ppwe});
    check({tag, ".PPPIS"}, pppis_o, e_pppis);
    check({tag, ".PPPWE"}, {31'd0, pppwe_o}, {31'd0, e_pppwe});
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] e_st, input logic [15:0] e_fl,
                         input logic [1:0] e_sst, input logic [1:0] e_sfl);
    check({tag, ".STALL"},   {16'd0, stall_o}, {16'd0, e_st});
    check({tag, ".FLUSH"},   {16'd0, flush_o}, {16'd0, e_fl});
    check({tag, ".S_STALL"}, {30'd0, s_stall}, {30'd0, e_sst});
    check({tag, ".S_FLUSH"}, {30'd0, s_flush}, {30'd0, e_sfl});
  endtask

  task automatic drive(input logic [31:0] w, input logic v, input logic p, input logic b,
                       input logic fc, input logic dc, input logic wd);
    if_is = w; if_valid = v; pen = p; ben = b; fdclr = fc; declr = dc; we_dec = wd;
  endtask

  initial begin
    rst = 1'b0;
    drive(32'h1111_1111, 1, 1, 1, 0, 0, 1);
    step(); step();
    chk_pipe("reset", 0, 0, 0, 0, 0, 0);
    chk_cnt("reset", 0, 0, 0, 0);

    // straight-line issue
    rst = 1'b1;
    drive(32'h8C08_0004, 1, 1, 1, 0, 0, 0); step();
    chk_pipe("A", 32'h8C08_0004, 0, 0, 0, 0, 0);
    drive(32'h0109_4020, 1, 1, 1, 0, 0, 1); step();
    chk_pipe("B", 32'h0109_4020, 32'h8C08_0004, 0, 0, 0, 0);
    drive(32'h2129_FFFF, 1, 1, 1, 0, 0, 1); step();
    chk_pipe("C", 32'h2129_FFFF, 32'h0109_4020, 32'h8C08_0004, 1, 0, 0);
    drive(32'h2129_FFFF, 0, 1, 1, 0, 0, 1); step();
    chk_pipe("D", 0, 32'h2129_FFFF, 32'h0109_4020, 1, 32'h8C08_0004, 1);

    // bubble from ID enters EX with decoded WE=1; must be masked
    drive(32'h8C08_0004, 1, 1, 1, 0, 0, 1); step();
    chk_pipe("E", 32'h8C08_0004, 0, 32'h2129_FFFF, 1, 32'h0109_4020, 1);
    drive(32'h0109_4020, 1, 1, 1, 0, 0, 1); step();
    chk_pipe("F", 32'h0109_4020, 32'h8C08_0004, 0, 0, 32'h2129_FFFF, 1);

    // load-use stall
    drive(32'h2129_FFFF, 1, 1, 0, 0, 1, 1); step();
    chk_pipe("G", 32'h0109_4020, 0, 32'h8C08_0004, 1, 0, 0);
    chk_cnt("G", 1, 0, 1, 0);
    drive(32'h2129_FFFF, 1, 1, 1, 0, 0, 1); step();
    chk_pipe("H", 32'h2129_FFFF, 32'h0109_4020, 0, 0, 32'h8C08_0004, 1);

    // jump flush
    drive(32'h1234_5678, 1, 1, 1, 1, 0, 1); step();
    chk_pipe("I", 0, 32'h2129_FFFF, 32'h0109_4020, 1, 0, 0);
    chk_cnt("I", 1, 1, 1, 1);
    drive(32'hAAAA_0001, 1, 1, 1, 0, 0, 0); step();
    chk_pipe("J", 32'hAAAA_0001, 0, 32'h2129_FFFF, 1, 32'h0109_4020, 1);

    // flush and bubble together
    drive(32'h5555_0000, 1, 1, 1, 1, 1, 1); step();
    chk_pipe("K", 0, 0, 0, 0, 32'h2129_FFFF, 1);
    chk_cnt("K", 2, 2, 2, 2);

    // saturation of the 2-bit instance
    step();
    chk_cnt("L", 3, 3, 3, 3);
    step();
    chk_cnt("M", 4, 4, 3, 3);
    step();
    chk_cnt("N", 5, 5, 3, 3);

    // PEN=0 holds ID
    drive(32'hBBBB_0002, 1, 1, 1, 0, 0, 0); step();
    check("P.IS", is_o, 32'hBBBB_0002);
    drive(32'hCCCC_0003, 1, 0, 1, 0, 0, 0); step();
    check("Q.IS", is_o, 32'hBBBB_0002);
    check("Q.PIS", pis_o, 32'hBBBB_0002);
    drive(32'hCCCC_0003, 1, 1, 1, 0, 0, 1); step();
    check("Q2.IS", is_o, 32'hCCCC_0003);

    // reset mid-stall beats hold, bubble and flush
    drive(32'hEEEE_0005, 1, 1, 0, 0, 1, 1); step();
    check("R0.IS", is_o, 32'hCCCC_0003);
    rst = 1'b0;
    drive(32'hEEEE_0005, 1, 1, 0, 1, 1, 1); step();
    chk_pipe("R", 0, 0, 0, 0, 0, 0);
    chk_cnt("R", 0, 0, 0, 0);
    rst = 1'b1;
    drive(32'hDDDD_0004, 1, 1, 1, 0, 0, 0); step();
    chk_pipe("S", 32'hDDDD_0004, 0, 0, 0, 0, 0);
    chk_cnt("S", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_pipe_track.md
INSTR_PIPE_TRACK -- requirements
Module: instr_pipe_track

Interface
REQ-001 SHALL have parameter NOP_WORD, default 32'h0000_0000, the instruction word inserted as a bubble (sll $0,$0,0).
REQ-002 SHALL have parameter CNT_W, default 16, the width of the event counters.
REQ-003 in_CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 in_RST  input  1  synchronous, active-low reset, sampled on the in_CLK rising edge.
REQ-005 in_IF_IS  input  32  instruction fetched this cycle.
REQ-006 in_IF_VALID  input  1  in_IF_IS is valid; 0 loads NOP_WORD into ID.
REQ-007 in_PEN  input  1  PC/IF-ID advance enable from the redirection unit; 1 = advance.
REQ-008 in_BEN  input  1  ID-stage enable from the redirection unit; 0 = hold ID (load-use stall).
REQ-009 in_FDCLR  input  1  flush IF/ID on a jump or jump-syscall.
REQ-010 in_DECLR  input  1  insert a bubble into ID/EX.
REQ-011 in_WE_DEC  input  1  register-write enable decoded for the instruction currently in ID.
REQ-012 out_IS  output  32  ID-stage instruction word.
REQ-013 out_PIS / out_PPIS / out_PPPIS  output  32 each  EX-, MEM- and WB-stage instruction words.
REQ-014 out_PPWE / out_PPPWE  output  1 each  register-write enables of the MEM- and WB-stage instructions.
REQ-015 out_STALLCNT / out_FLUSHCNT  output  CNT_W each  counts of bubble cycles and flush cycles.

Function
REQ-016 All outputs SHALL be registered; no combinational path from input to output.
REQ-017 The ID register SHALL update with priority FDCLR > hold > load: in_FDCLR=1 -> NOP_WORD; else (in_BEN=0 or in_PEN=0) -> hold; else in_IF_VALID ? in_IF_IS : NOP_WORD.
REQ-018 The EX register SHALL load NOP_WORD with WE=0 when in_DECLR=1, and otherwise out_IS with WE=in_WE_DEC.
REQ-019 The MEM and WB stages SHALL advance every cycle unconditionally (PPIS<=PIS, PPPIS<=PPIS), and the write enables SHALL travel with their words.
REQ-020 A stage holding NOP_WORD SHALL always carry WE=0, even when it entered through REQ-018's load path.
REQ-021 Latency: a word accepted into ID at edge N SHALL appear on out_PIS at N+1, out_PPIS at N+2 and out_PPPIS at N+3, provided no hold or bubble occurs.
REQ-022 Simultaneous in_DECLR=1 and in_BEN=0 SHALL hold ID and bubble EX (load-use stall), so the held word issues one cycle later.
REQ-023 Simultaneous in_FDCLR=1 and in_DECLR=1 SHALL clear both ID and EX in the same edge.
REQ-024 out_STALLCNT SHALL increment on each edge where in_DECLR=1, and out_FLUSHCNT on each edge where in_FDCLR=1.
REQ-025 Both counters SHALL saturate at all-ones, with no wrap-around.

Reset
REQ-026 When in_RST=0 at an edge, all four instruction registers SHALL become NOP_WORD, all WE bits 0, and both counters 0.
REQ-027 Reset SHALL take priority over in_FDCLR, in_DECLR and the hold conditions.
REQ-028 Reset asserted mid-stall SHALL discard the held word; the first word loaded after release is the in_IF_IS sampled on the first edge with in_RST=1.

Structure
REQ-029 NOP_WORD and the MIPS opcode/funct field positions (OP 31:26, RS 25:21, RT 20:16, RD 15:11, FUNCT 5:0) SHALL live in a shared package also used by the redirection unit.
REQ-030 One sub-module, pipe_stage_reg, SHALL be used per stage: a 33-bit word+WE register with load, clear and hold inputs, instantiated four times.
REQ-031 The saturating counters SHALL be inline logic, not separate modules.

Verification
REQ-032 Reset, then feed 0x8C080004, 0x01094020, 0x2129FFFF with in_PEN=in_BEN=1 -> 0x8C080004 appears on out_IS, out_PIS, out_PPIS and out_PPPIS on consecutive cycles, with out_PPWE=1 following it.
REQ-033 Load-use stall: in_DECLR=1 and in_BEN=0 for one cycle with 0x01094020 in ID -> out_PIS=0x0 for one cycle, out_IS holds 0x01094020, then it issues; out_STALLCNT=1.
REQ-034 Jump flush: in_FDCLR=1 with 0x2129FFFF in ID -> out_IS=0x0 next cycle and out_FLUSHCNT=1; downstream stages are unaffected.
REQ-035 Saturation: preload out_STALLCNT to 0xFFFE (or CNT_W=2 with three bubbles) -> the counter stops at all-ones.
REQ-036 Reset mid-stall: in_RST=0 during an in_BEN=0 hold -> all outputs go to NOP/0 at that edge; the word present on the first edge with in_RST=1 enters ID.
